// File: rtl/add_serial_pkg.sv
// Shared definitions for the serial-adder feeder: FSM state encoding and default sizing.
package add_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } feeder_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LAT   = 9;

endpackage

// File: rtl/add_serial_feeder_fifo.sv
// Operand-pair FIFO for the serial-adder feeder; registered read head, no fall-through.
module add_serial_feeder_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/add_serial_feeder.sv
// Feeds buffered operand pairs to the 8-bit serial adder one at a time and returns results.
// Optional result checker enabled by defining ADD_SERIAL_FEEDER_CHECK_EN (adds port res_err).
module add_serial_feeder
    import add_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4,
    parameter int LAT   = DEF_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
    ,
    output logic             res_err
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;

    feeder_state_t      state_q;
    feeder_state_t      state_d;
    logic [TW-1:0]      timer;
    logic [2*WIDTH-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               push;
    logic               latch;
    logic               capture;

    assign in_ready = (fifo_count != CW'(DEPTH));
    assign push     = in_valid && !fifo_full;
    assign latch    = !fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_HOLD) && res_ready));
    assign capture  = (state_q == S_WAIT) && (timer == '0);
    assign add_en   = (state_q == S_ISSUE);
    assign busy     = (state_q != S_IDLE);

    add_serial_feeder_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (latch),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (latch) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (capture) state_d = S_HOLD;
            S_HOLD: begin
                if (res_ready) state_d = latch ? S_ISSUE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timer is loaded on entry to S_ISSUE and counts the en cycle itself,
    // so out is sampled at the end of the LAT-th cycle counting the en cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer   <= '0;
            add_a   <= '0;
            add_b   <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                add_a <= fifo_rdata[2*WIDTH-1:WIDTH];
                add_b <= fifo_rdata[WIDTH-1:0];
                timer <= TW'(LAT - 1);
            end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && (timer != '0)) begin
                timer <= timer - 1'b1;
            end
        end
    end

`ifdef ADD_SERIAL_FEEDER_CHECK_EN
    logic [WIDTH-1:0] expected;
    assign expected = add_a + add_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
            res_err   <= 1'b0;
`endif
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= add_out;
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
            res_err   <= (add_out != expected);
`endif
        end else if ((state_q == S_HOLD) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_serial_feeder.sv
// Self-checking bench for add_serial_feeder with a timed behavioural model of the serial adder.
module tb_add_serial_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             add_en;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic             busy;
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
    logic             res_err;
`endif

    int checks = 0;
    int errors = 0;

    add_serial_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
        ,
        .res_err   (res_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial adder model: the sum only becomes correct LAT-1 cycles after the en cycle.
    int   since_en = 100;
    bit   fault = 1'b0;
    logic [WIDTH-1:0] true_sum;
    always @(posedge clk) begin
        if (add_en === 1'b1) since_en <= 1;
        else if (since_en < 100) since_en <= since_en + 1;
    end
    assign true_sum = add_a + add_b;
    assign add_out  = fault ? '0 : ((since_en >= LAT - 1) ? true_sum : ~true_sum);

    // Observation log, sampled on the falling edge.
    int               acc_cyc[$];
    logic [WIDTH-1:0] acc_sum[$];
    int               en_cyc[$];
    int               rv_cyc[$];
    int               idle_cyc[$];
    logic [WIDTH-1:0] res_q[$];
    logic             err_q[$];
    logic             rv_prev = 1'b0;
    logic [WIDTH-1:0] mon_sum;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready === 1'b1) begin
                mon_sum = in_a + in_b;
                acc_cyc.push_back(cyc);
                acc_sum.push_back(mon_sum);
            end
            if (add_en === 1'b1) en_cyc.push_back(cyc);
            if (res_valid === 1'b1 && !rv_prev) rv_cyc.push_back(cyc);
            if (busy === 1'b0) idle_cyc.push_back(cyc);
            if (res_valid === 1'b1 && res_ready) begin
                res_q.push_back(res_data);
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
                err_q.push_back(res_err);
`else
                err_q.push_back(1'b0);
`endif
            end
        end
        rv_prev = (res_valid === 1'b1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        acc_cyc.delete(); acc_sum.delete(); en_cyc.delete(); rv_cyc.delete();
        idle_cyc.delete(); res_q.delete(); err_q.delete();
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int bound, output bit ok);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (ok) in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (res_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (add_en !== 1'b0) begin errors++; $display("FAIL reset_add_en got %b want 0", add_en); end
        checks++; if (add_a !== 8'h00 || add_b !== 8'h00) begin errors++; $display("FAIL reset_add_ab got %h/%h want 00/00", add_a, add_b); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data got %h want 00", res_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) step();
        clear_model();
    endtask

    task automatic single_op(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] want);
        bit ok, ok2;
        int d;
        clear_model();
        res_ready = 1'b1;
        push(a, b, 10, ok);
        wait_results(1, 60, ok2);
        repeat (5) step();
        checks++; if (!ok || !ok2) begin errors++; $display("FAIL %s_timeout got acc=%0b res=%0b want 1/1", name, ok, ok2); end
        checks++; if (en_cyc.size() != 1) begin errors++; $display("FAIL %s_en_count got %0d want 1", name, en_cyc.size()); end
        d = (en_cyc.size() > 0 && acc_cyc.size() > 0) ? en_cyc[0] - acc_cyc[0] : -1;
        checks++; if (d != 2) begin errors++; $display("FAIL %s_en_latency got %0d want 2", name, d); end
        d = (en_cyc.size() > 0 && rv_cyc.size() > 0) ? rv_cyc[0] - en_cyc[0] : -1;
        checks++; if (d != LAT) begin errors++; $display("FAIL %s_res_latency got %0d want %0d", name, d, LAT); end
        checks++; if (res_q.size() != 1 || res_q[0] !== want) begin errors++; $display("FAIL %s_data got %h (n=%0d) want %h", name, (res_q.size() > 0) ? res_q[0] : 8'hxx, res_q.size(), want); end
    endtask

    task automatic test_single();
        single_op("single", 8'h35, 8'h4A, 8'h7F);
    endtask

    task automatic test_overflow();
        single_op("overflow", 8'hFF, 8'h02, 8'h01);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] want [4];
        bit ok, ok2;
        int idles;
        want[0] = 8'd3; want[1] = 8'd7; want[2] = 8'd11; want[3] = 8'd15;
        clear_model();
        res_ready = 1'b1;
        ok2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(8'(2*i+1), 8'(2*i+2), 10, ok);
            ok2 = ok2 && ok;
        end
        wait_results(4, 150, ok);
        repeat (3) step();
        checks++; if (!ok || !ok2) begin errors++; $display("FAIL b2b_timeout got res=%0d want 4", res_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= res_q.size() || res_q[i] !== want[i] || res_q[i] !== acc_sum[i]) begin
                errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, (i < res_q.size()) ? res_q[i] : 8'hxx, want[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (i >= en_cyc.size() || en_cyc[i] - en_cyc[i-1] != LAT + 1) begin
                errors++; $display("FAIL b2b_en_spacing[%0d] got %0d want %0d", i, (i < en_cyc.size()) ? en_cyc[i] - en_cyc[i-1] : -1, LAT + 1);
            end
        end
        idles = 0;
        if (en_cyc.size() == 4)
            foreach (idle_cyc[j]) if (idle_cyc[j] > en_cyc[0] && idle_cyc[j] < en_cyc[3]) idles++;
        checks++; if (en_cyc.size() != 4 || idles != 0) begin errors++; $display("FAIL b2b_idle got idles=%0d ens=%0d want 0/4", idles, en_cyc.size()); end
    endtask

    task automatic test_backpressure();
        bit ok, got6;
        int n_acc;
        clear_model();
        res_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'(16*i + 1), 8'(i + 5), 15, ok);
            if (!ok) break;
            n_acc++;
        end
        @(negedge clk);
        checks++; if (n_acc != 5 || acc_sum.size() != 5) begin errors++; $display("FAIL bp_accepted got %0d/%0d want 5", n_acc, acc_sum.size()); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (en_cyc.size() != 1) begin errors++; $display("FAIL bp_issued got %0d want 1", en_cyc.size()); end
        @(posedge clk);
        #1 res_ready = 1'b1;
        got6 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got6 = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++; if (!got6) begin errors++; $display("FAIL bp_sixth_accept got 0 want 1"); end
        wait_results(6, 200, ok);
        repeat (3) step();
        checks++; if (res_q.size() != 6 || acc_sum.size() != 6) begin errors++; $display("FAIL bp_count got %0d/%0d want 6", res_q.size(), acc_sum.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= res_q.size() || i >= acc_sum.size() || res_q[i] !== acc_sum[i]) begin
                errors++; $display("FAIL bp_data[%0d] got %h want %h", i, (i < res_q.size()) ? res_q[i] : 8'hxx, (i < acc_sum.size()) ? acc_sum[i] : 8'hxx);
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 30;
        bit done, ok;
        int bad;
        clear_model();
        done = 1'b0;
        fork
            begin
                bit pok;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 200, pok);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    res_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
                res_ready = 1'b1;
            end
        join
        wait_results(N, 800, ok);
        repeat (3) step();
        checks++; if (res_q.size() != N || acc_sum.size() != N) begin errors++; $display("FAIL rand_count got %0d/%0d want %0d", res_q.size(), acc_sum.size(), N); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (i >= res_q.size() || i >= acc_sum.size() || res_q[i] !== acc_sum[i]) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL rand_data[%0d] got %h want %h", i, (i < res_q.size()) ? res_q[i] : 8'hxx, (i < acc_sum.size()) ? acc_sum[i] : 8'hxx);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_model();
        res_ready = 1'b1;
        push(8'd10, 8'd20, 10, ok);
        push(8'd30, 8'd40, 10, ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_cyc.size() >= 1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_no_issue got 0 want 1"); end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid got %b want 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        checks++; if (add_en !== 1'b0) begin errors++; $display("FAIL rstmid_add_en got %b want 0", add_en); end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        repeat (30) step();
        checks++; if (res_q.size() != 0 || rv_cyc.size() != 0 || en_cyc.size() != 0) begin
            errors++; $display("FAIL rstmid_stale got res=%0d ens=%0d want 0/0", rv_cyc.size(), en_cyc.size());
        end
    endtask

`ifdef ADD_SERIAL_FEEDER_CHECK_EN
    task automatic test_check();
        bit ok;
        clear_model();
        res_ready = 1'b1;
        fault = 1'b1;
        push(8'd1, 8'd1, 10, ok);
        wait_results(1, 60, ok);
        fault = 1'b0;
        checks++; if (res_q.size() < 1 || res_q[0] !== 8'h00 || err_q[0] !== 1'b1) begin
            errors++; $display("FAIL chk_bad_adder got n=%0d err=%b want err=1", res_q.size(), (err_q.size() > 0) ? err_q[0] : 1'bx);
        end
        repeat (3) step();
        for (int i = 0; i < 4; i++) push(8'(2*i+1), 8'(2*i+2), 10, ok);
        wait_results(5, 150, ok);
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (i >= err_q.size() || err_q[i] !== 1'b0) begin
                errors++; $display("FAIL chk_good[%0d] got %b want 0", i, (i < err_q.size()) ? err_q[i] : 1'bx);
            end
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef ADD_SERIAL_FEEDER_CHECK_EN
        test_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
